imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion to the byte-addressed, big-endian instruction memory.
//  Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into one 32-bit word.
//  Issues one-cycle word writes ({mem[a],mem[a+1],mem[a+2],mem[a+3]} = wr_data[31:0]) into the memory array.
//  Sits between the program source (testbench/UART/boot ROM) and the imem write port; core is held while busy.
// PARAMETERS
//  MEM_SIZE   4095  capacity in bytes; byte offsets >= MEM_SIZE are out of range
//  BASE_ADDR  0     byte address of first word written; must be 4-byte aligned
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  start       in   1   pulse: begin a new load (honoured in IDLE and DONE only)
//  in_valid    in   1   in_data/in_last valid
//  in_data     in   8   program byte, stream order = ascending address
//  in_last     in   1   marks final byte of the program
//  in_ready    out  1   loader accepts byte this cycle (transfer = in_valid & in_ready)
//  wr_en       out  1   one-cycle word write strobe
//  wr_addr     out  64  byte address of word MSB byte (BASE_ADDR + 4*k)
//  wr_data     out  32  big-endian packed word, first stream byte in [31:24]
//  busy        out  1   high in COLLECT and WRITE; core must be held in reset
//  done        out  1   sticky, high in DONE
//  overflow    out  1   sticky, set when a byte at offset >= MEM_SIZE is received
//  byte_count  out  64  in-range bytes accepted this load (saturates at MEM_SIZE)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, wr_en, busy, done, overflow = 0; wr_addr, wr_data, byte_count = 0; word buffer cleared.
//  Reset wins over every other event at the same edge, including mid-load; no write is issued for a partial word.
//  States:
//   IDLE -> COLLECT on start; clears byte_count, overflow, and the buffer.
//   COLLECT: in_ready=1. Each accepted in-range byte goes to lane byte_count[1:0].
//    Lane 0 -> buf[31:24], lane 3 -> buf[7:0]. byte_count then increments.
//    -> WRITE when the accepted byte fills lane 3, OR carries in_last, OR makes byte_count == MEM_SIZE.
//    Out-of-range byte (byte_count == MEM_SIZE): consumed, discarded, overflow=1.
//     Stay in COLLECT; on in_last go to DONE (no write).
//   WRITE: exactly one cycle. in_ready=0, wr_en=1.
//    wr_addr = BASE_ADDR + ((byte_count-1) & ~3).
//    wr_data = buf; unfilled lanes = 8'h00.
//    Buffer clears at exit. -> DONE if in_last was seen, else -> COLLECT.
//   DONE: done=1, busy=0, in_ready=0. start -> COLLECT (clears done, overflow, byte_count).
//  start in COLLECT/WRITE is ignored. in_valid with in_ready=0 is not a transfer.
//   Source must hold in_data/in_last stable until accepted.
//  wr_en is low in every state except WRITE. wr_addr/wr_data are don't-care when wr_en=0.
//   They are registered and change only on entry to WRITE.
//  Throughput: 4 bytes per 5 cycles max (WRITE bubble). Latency: last byte of a word -> wr_en on next cycle.
//  Single-byte program: one write {b,24'h0} @BASE_ADDR.
//  byte_count never exceeds MEM_SIZE; address arithmetic is 64-bit, no wrap.
// TESTING
//  T1 start; 8 bytes 00 50 00 93 00 10 01 13 (last on 8th)
//     -> wr 0x00500093@0, 0x00100113@4; done=1, byte_count=8, overflow=0.
//  T2 5 bytes AA BB CC DD EE(last)
//     -> wr 0xAABBCCDD@0, 0xEE000000@4; done=1, byte_count=5.
//  T3 T1 stream with random in_valid gaps; check in_ready=0 during each WRITE
//     -> identical writes; no byte lost or duplicated.
//  T4 MEM_SIZE=6; bytes 01..08 (last on 08)
//     -> wr 0x01020304@0, 0x05060000@4; overflow=1, byte_count=6, done=1; exactly 2 wr_en pulses.
//  T5 reset asserted after 2 bytes in COLLECT
//     -> next cycle all outputs 0, state IDLE, no wr_en. Restart loads T2 data correctly @0.
//  T6 start pulsed during COLLECT -> ignored.
//     start in DONE after T4 -> done=0, overflow=0, byte_count=0; next word lands @BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream to 32-bit word packer feeding the big-endian instruction memory write port.
// Collects up to four bytes per word, issues a single-cycle write, and tracks overflow past MEM_SIZE.
module imem_loader #(
  parameter int          MEM_SIZE  = 4095,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [63:0] byte_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [63:0] MemSize64 = 64'(MEM_SIZE);

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [63:0] byte_count_q, byte_count_d;
  logic        overflow_q, overflow_d;
  logic        last_q, last_d;
  logic [63:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic [1:0]  lane;
  logic [31:0] packed_buf;

  // Lane 0 lands in the MSB byte; ~lane equals 3-lane for a 2-bit lane index.
  assign lane = byte_count_q[1:0];
  always_comb begin
    packed_buf = buf_q;
    packed_buf[{~lane, 3'b000} +: 8] = in_data;
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    buf_d        = buf_q;
    byte_count_d = byte_count_q;
    overflow_d   = overflow_q;
    last_d       = last_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = COLLECT;
          buf_d        = '0;
          byte_count_d = '0;
          overflow_d   = 1'b0;
          last_d       = 1'b0;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (byte_count_q < MemSize64) begin
            buf_d        = packed_buf;
            byte_count_d = byte_count_q + 64'd1;
            last_d       = in_last;
            if (lane == 2'd3 || in_last || byte_count_d == MemSize64) begin
              state_d   = WRITE;
              wr_addr_d = BASE_ADDR + {byte_count_q[63:2], 2'b00};
              wr_data_d = packed_buf;
            end
          end else begin
            // Past capacity: swallow the byte so the source is never stalled.
            overflow_d = 1'b1;
            if (in_last) begin
              state_d = DONE;
              last_d  = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        buf_d   = '0;
        state_d = last_q ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
      last_q       <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
      last_q       <= last_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign in_ready   = (state_q == COLLECT);
  assign wr_en      = (state_q == WRITE);
  assign busy       = (state_q == COLLECT) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads scored against a reference packing model.
// Uses MEM_SIZE=10 (not a multiple of 4) and a non-zero BASE_ADDR so address and boundary faults show.
module tb_imem_loader;

  localparam int          MEM  = 10;
  localparam logic [63:0] BASE = 64'h1000;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, busy, done, overflow;
  logic [63:0] wr_addr, byte_count;
  logic [31:0] wr_data;

  imem_loader #(.MEM_SIZE(MEM), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic        rdy;
  } wr_t;

  typedef struct {
    int               n;
    logic [0:15][7:0] b;
    bit               gaps;
    logic [63:0]      exp_cnt;
    logic             exp_ovf;
    int               exp_writes;
  } vec_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint      m_cnt;
  logic [31:0] m_buf;

  always @(negedge clk) begin
    wr_t w;
    if (wr_en) begin
      w.addr = wr_addr;
      w.data = wr_data;
      w.rdy  = in_ready;
      obs_q.push_back(w);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_buf = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] b, input logic last);
    wr_t w;
    int  lane;
    if (m_cnt < MEM) begin
      lane = int'(m_cnt % 4);
      m_buf[31 - 8*lane -: 8] = b;
      m_cnt++;
      if (lane == 3 || last || m_cnt == MEM) begin
        w.addr = BASE + 64'((m_cnt - 1) / 4 * 4);
        w.data = m_buf;
        w.rdy  = 1'b0;
        exp_q.push_back(w);
        m_buf = '0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    else           model_accept(b, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_reset();
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done", 64'(done), 64'd1);
  endtask

  task automatic drain(input int exp_writes);
    wr_t e, o;
    repeat (2) @(negedge clk);
    check("n_writes", 64'(obs_q.size()), 64'(exp_writes));
    check("n_model", 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("wr_addr", o.addr, e.addr);
      check("wr_data", 64'(o.data), 64'(e.data));
      check("ready_in_write", 64'(o.rdy), 64'd0);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_byte_count"}, byte_count, 64'd0);
    check({tag, "_wr_addr"}, wr_addr, 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0].n = 8;  vecs[0].b = 128'h0050_0093_0010_0113_0000_0000_0000_0000;
    vecs[0].gaps = 0; vecs[0].exp_cnt = 8;  vecs[0].exp_ovf = 0; vecs[0].exp_writes = 2;
    vecs[1].n = 5;  vecs[1].b = 128'hAABB_CCDD_EE00_0000_0000_0000_0000_0000;
    vecs[1].gaps = 0; vecs[1].exp_cnt = 5;  vecs[1].exp_ovf = 0; vecs[1].exp_writes = 2;
    vecs[2].n = 8;  vecs[2].b = 128'h0050_0093_0010_0113_0000_0000_0000_0000;
    vecs[2].gaps = 1; vecs[2].exp_cnt = 8;  vecs[2].exp_ovf = 0; vecs[2].exp_writes = 2;
    vecs[3].n = 12; vecs[3].b = 128'h0102_0304_0506_0708_090A_0B0C_0000_0000;
    vecs[3].gaps = 0; vecs[3].exp_cnt = 10; vecs[3].exp_ovf = 1; vecs[3].exp_writes = 3;
    vecs[4].n = 1;  vecs[4].b = 128'h5A00_0000_0000_0000_0000_0000_0000_0000;
    vecs[4].gaps = 0; vecs[4].exp_cnt = 1;  vecs[4].exp_ovf = 0; vecs[4].exp_writes = 1;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      pulse_start();
      check("start_done", 64'(done), 64'd0);
      check("start_overflow", 64'(overflow), 64'd0);
      check("start_byte_count", byte_count, 64'd0);
      check("start_busy", 64'(busy), 64'd1);
      for (int j = 0; j < vecs[i].n; j++) begin
        if (i == 0 && j == 4) begin
          @(negedge clk);
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        send(vecs[i].b[j], (j == vecs[i].n - 1), vecs[i].gaps);
      end
      wait_done();
      check("end_byte_count", byte_count, vecs[i].exp_cnt);
      check("end_overflow", 64'(overflow), 64'(vecs[i].exp_ovf));
      check("end_busy", 64'(busy), 64'd0);
      check("end_in_ready", 64'(in_ready), 64'd0);
      drain(vecs[i].exp_writes);
    end

    // Reset in the middle of a word: no write, everything back to zero.
    pulse_start();
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_no_write", 64'(obs_q.size()), 64'd0);
    check("midreset_idle_ready", 64'(in_ready), 64'd0);
    obs_q.delete();
    pulse_start();
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    send(8'hDD, 1'b0, 1'b0);
    send(8'hEE, 1'b1, 1'b0);
    wait_done();
    check("restart_byte_count", byte_count, 64'd5);
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
